// File: rtl/voice_allocator_pkg.sv
// Shared types for the keyboard voice allocator: slot record, FSM states and commit actions.
package kbd_pkg;

  localparam int KBD_MAX_VOICES = 3;
  localparam int KBD_KEY_W      = 5;
  localparam int KBD_PRD_W      = 32;

  typedef struct packed {
    logic                 active;
    logic [KBD_KEY_W-1:0] key;
    logic [KBD_PRD_W-1:0] prd;
  } voice_t;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, COMMIT} va_state_t;

  // Decided at the end of SCAN, applied to the slot array at COMMIT
  typedef enum logic [2:0] {
    ACT_RETRIG,
    ACT_APPEND,
    ACT_REMOVE,
    ACT_STEAL,
    ACT_DROP
  } va_act_t;

  function automatic voice_t mk_voice(input logic [KBD_KEY_W-1:0] key,
                                      input logic [KBD_PRD_W-1:0] prd);
    voice_t v;
    v.active = 1'b1;
    v.key    = key;
    v.prd    = prd;
    return v;
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Key-event handshake plus committed voice outputs of the voice allocator.
interface voice_allocator_if #(
  parameter int NUM_VOICES = 3,
  parameter int PRD_W      = 32,
  parameter int KEY_W      = 5
);

  logic                        key_valid;
  logic                        key_ready;
  logic                        key_on;
  logic [KEY_W-1:0]            key_id;
  logic [PRD_W-1:0]            key_prd;
  logic [NUM_VOICES*PRD_W-1:0] voice_prd;
  logic [1:0]                  notes;
  logic                        upd_done;
  logic                        drop;

  modport master (
    output key_valid, key_on, key_id, key_prd,
    input  key_ready, voice_prd, notes, upd_done, drop
  );

  modport slave (
    input  key_valid, key_on, key_id, key_prd,
    output key_ready, voice_prd, notes, upd_done, drop
  );

endinterface

// File: rtl/voice_allocator.sv
// Keeps active voices compacted oldest-first in slots 0..notes-1 and publishes them only at COMMIT.
// Define VOICE_STEAL_EN to evict the oldest voice on note-on to a full list (default: drop the event).
module voice_allocator
  import kbd_pkg::*;
#(
  parameter int NUM_VOICES = KBD_MAX_VOICES,
  parameter int PRD_W      = KBD_PRD_W,
  parameter int KEY_W      = KBD_KEY_W
) (
  input logic              clk,
  input logic              reset,
  voice_allocator_if.slave bus
);

  localparam int            IW   = $clog2(NUM_VOICES);
  localparam logic [1:0]    NV2  = 2'(NUM_VOICES);
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  va_state_t        state;
  va_act_t          act;
  voice_t           slots [NUM_VOICES];
  voice_t           nxt   [NUM_VOICES];
  logic [1:0]       cnt;
  logic [1:0]       nxt_cnt;
  logic [1:0]       cnt_m1;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_nx;
  logic [IW-1:0]    hit_idx;
  logic [IW-1:0]    hit_at;
  logic [IW-1:0]    top;
  logic             hit_found;
  logic             scan_hit;
  logic             hit_any;
  logic             ev_on;
  logic [KEY_W-1:0] ev_key;
  logic [PRD_W-1:0] ev_prd;

  assign scan_hit      = slots[idx].active && (slots[idx].key == ev_key);
  assign hit_any       = hit_found | scan_hit;
  assign hit_at        = hit_found ? hit_idx : idx;
  assign cnt_m1        = cnt - 2'd1;
  assign top           = IW'(cnt_m1);
  assign idx_nx        = idx + IW'(1);
  assign bus.key_ready = (state == IDLE);

  // Final slot image written at COMMIT; also the source of the published outputs
  always_comb begin
    nxt     = slots;
    nxt_cnt = cnt;
    case (act)
      ACT_RETRIG: nxt[hit_idx].prd = ev_prd;
      ACT_APPEND: begin
        nxt[IW'(cnt)] = mk_voice(ev_key, ev_prd);
        nxt_cnt       = cnt + 2'd1;
      end
      ACT_REMOVE: begin
        nxt[top] = '0;
        nxt_cnt  = cnt_m1;
      end
      ACT_STEAL:  nxt[LAST] = mk_voice(ev_key, ev_prd);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      act       <= ACT_DROP;
      cnt       <= '0;
      idx       <= '0;
      hit_idx   <= '0;
      hit_found <= 1'b0;
      ev_on     <= 1'b0;
      ev_key    <= '0;
      ev_prd    <= '0;
      for (int i = 0; i < NUM_VOICES; i++) slots[i] <= '0;
      bus.voice_prd <= '0;
      bus.notes     <= '0;
      bus.upd_done  <= 1'b0;
      bus.drop      <= 1'b0;
    end else begin
      bus.upd_done <= 1'b0;
      bus.drop     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.key_valid) begin
            ev_on     <= bus.key_on;
            ev_key    <= bus.key_id;
            ev_prd    <= bus.key_prd;
            idx       <= '0;
            hit_found <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (scan_hit && !hit_found) begin
            hit_found <= 1'b1;
            hit_idx   <= idx;
          end
          if (idx != LAST) begin
            idx <= idx_nx;
          end else begin
            // Last slot examined: the hit from this cycle is folded in via hit_at
            hit_idx <= hit_at;
            state   <= COMMIT;
            if (ev_on) begin
              if (hit_any) begin
                act <= ACT_RETRIG;
              end else if (cnt != NV2) begin
                act <= ACT_APPEND;
              end else begin
`ifdef VOICE_STEAL_EN
                act   <= ACT_STEAL;
                idx   <= '0;
                state <= SHIFT;
`else
                act   <= ACT_DROP;
`endif
              end
            end else if (!hit_any) begin
              act <= ACT_DROP;
            end else begin
              act <= ACT_REMOVE;
              if (hit_at != top) begin
                idx   <= hit_at;
                state <= SHIFT;
              end
            end
          end
        end
        SHIFT: begin
          // Close the gap one slot per cycle; the vacated top slot is cleared at COMMIT
          slots[idx] <= slots[idx_nx];
          if (idx_nx == top) state <= COMMIT;
          else               idx   <= idx_nx;
        end
        COMMIT: begin
          slots <= nxt;
          cnt   <= nxt_cnt;
          for (int i = 0; i < NUM_VOICES; i++) bus.voice_prd[i*PRD_W +: PRD_W] <= nxt[i].prd;
          bus.notes    <= nxt_cnt;
          bus.upd_done <= 1'b1;
          bus.drop     <= (act == ACT_DROP);
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: stimulus pushes expected commits, a negedge monitor pops and compares.
module tb_voice_allocator;

  localparam int NV = 3;
  localparam int PW = 32;
  localparam int KW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  voice_allocator_if #(.NUM_VOICES(NV), .PRD_W(PW), .KEY_W(KW)) bus ();

  voice_allocator #(.NUM_VOICES(NV), .PRD_W(PW), .KEY_W(KW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [NV*PW-1:0] prd;
    logic [1:0]       notes;
    logic             drop;
    int               lat;
    string            name;
  } exp_t;

  exp_t             q[$];
  exp_t             mon_e;
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               acc_cyc = 0;
  int               acc_cnt = 0;
  logic [NV*PW-1:0] snap_prd = '0;
  logic [1:0]       snap_notes = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [NV*PW-1:0] pk(input int unsigned s0, input int unsigned s1,
                                          input int unsigned s2);
    return {PW'(s2), PW'(s1), PW'(s0)};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.key_valid && bus.key_ready && !reset) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
  end

  // Monitor: every commit must match the oldest expectation; between commits outputs must hold
  always @(negedge clk) begin
    if (reset) begin
      snap_prd   <= '0;
      snap_notes <= '0;
    end else if (bus.upd_done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_upd_done: got 1 expected 0");
      end else begin
        mon_e = q.pop_front();
        chk({mon_e.name, " voice_prd"}, bus.voice_prd, mon_e.prd);
        chk({mon_e.name, " notes"}, bus.notes, mon_e.notes);
        chk({mon_e.name, " drop"}, bus.drop, mon_e.drop);
        chk({mon_e.name, " latency"}, cyc - acc_cyc - 1, mon_e.lat);
        chk({mon_e.name, " ready_at_done"}, bus.key_ready, 1);
      end
      snap_prd   <= bus.voice_prd;
      snap_notes <= bus.notes;
    end else begin
      chk("stable_voice_prd", bus.voice_prd, snap_prd);
      chk("stable_notes", bus.notes, snap_notes);
      chk("drop_without_done", bus.drop, 0);
    end
  end

  task automatic send(input string nm, input bit on, input int unsigned id, input int unsigned prd,
                      input logic [NV*PW-1:0] eprd, input int en, input bit edrop, input int elat);
    exp_t e;
    int   a0;
    bit   done;
    e.prd   = eprd;
    e.notes = 2'(en);
    e.drop  = edrop;
    e.lat   = elat;
    e.name  = nm;
    q.push_back(e);
    @(negedge clk);
    a0            = acc_cnt;
    bus.key_valid = 1'b1;
    bus.key_on    = on;
    bus.key_id    = KW'(id);
    bus.key_prd   = PW'(prd);
    done          = 1'b0;
    // key_valid stays high through the busy period; only one accept may result
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (bus.upd_done) done = 1'b1;
      else if (acc_cnt != a0) chk({nm, " busy_ready"}, bus.key_ready, 0);
    end
    bus.key_valid = 1'b0;
    chk({nm, " done_seen"}, done, 1);
    chk({nm, " accepts"}, acc_cnt - a0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic build_full();
    send("on9",  1'b1, 9,  113636, pk(113636, 0, 0),         1, 1'b0, 4);
    send("on13", 1'b1, 13, 90193,  pk(113636, 90193, 0),     2, 1'b0, 4);
    send("on16", 1'b1, 16, 75843,  pk(113636, 90193, 75843), 3, 1'b0, 4);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_valid = 1'b0;
    bus.key_on    = 1'b0;
    bus.key_id    = '0;
    bus.key_prd   = '0;
    repeat (3) @(negedge clk);
    chk("rst key_ready", bus.key_ready, 1);
    chk("rst notes", bus.notes, 0);
    chk("rst voice_prd", bus.voice_prd, 0);
    chk("rst upd_done", bus.upd_done, 0);
    chk("rst drop", bus.drop, 0);
    reset = 1'b0;

    build_full();
`ifdef VOICE_STEAL_EN
    send("full_on20", 1'b1, 20, 56818, pk(90193, 75843, 56818), 3, 1'b0, 6);
`else
    send("full_on20", 1'b1, 20, 56818, pk(113636, 90193, 75843), 3, 1'b1, 4);
`endif

    do_reset();
    build_full();
    send("off9",      1'b0, 9,  0,     pk(90193, 75843, 0),     2, 1'b0, 6);
    send("retrig13",  1'b1, 13, 45097, pk(45097, 75843, 0),     2, 1'b0, 4);
    send("off3",      1'b0, 3,  0,     pk(45097, 75843, 0),     2, 1'b1, 4);
    send("on21",      1'b1, 21, 1000,  pk(45097, 75843, 1000),  3, 1'b0, 4);
    send("off16_mid", 1'b0, 16, 0,     pk(45097, 1000, 0),      2, 1'b0, 5);
    send("off21_top", 1'b0, 21, 0,     pk(45097, 0, 0),         1, 1'b0, 4);
    send("retrig13b", 1'b1, 13, 777,   pk(777, 0, 0),           1, 1'b0, 4);
    send("off13",     1'b0, 13, 0,     pk(0, 0, 0),             0, 1'b0, 4);
    send("off_empty", 1'b0, 13, 0,     pk(0, 0, 0),             0, 1'b1, 4);

    // Reset while the note-off is in SHIFT: the event is abandoned, no commit expected
    do_reset();
    build_full();
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_on    = 1'b0;
    bus.key_id    = KW'(9);
    bus.key_prd   = '0;
    repeat (4) @(negedge clk);
    chk("mid_shift busy", bus.key_ready, 0);
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst voice_prd", bus.voice_prd, 0);
    chk("mid_rst notes", bus.notes, 0);
    chk("mid_rst key_ready", bus.key_ready, 1);
    chk("mid_rst upd_done", bus.upd_done, 0);
    reset = 1'b0;
    send("after_rst_on5", 1'b1, 5, 500, pk(500, 0, 0), 1, 1'b0, 4);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
